// File: rtl/snes_usb_pkg.sv
// Shared types and constants for the SNES B-bus to FT245 USB FIFO bridge.
package snes_usb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] ADDR_STAT = 8'hFE;
  localparam logic [DATA_W-1:0] ADDR_DATA = 8'hFF;

  localparam int unsigned STAT_RXV = 7;
  localparam int unsigned STAT_TXR = 6;
  localparam int unsigned STAT_ONE = 5;
  localparam int unsigned STAT_OVR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_RD_RECOVER,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_RECOVER
  } state_e;

  // Status byte presented on a $21FE read.
  function automatic logic [DATA_W-1:0] status_byte(input logic rxv, input logic txr,
                                                    input logic ovr);
    logic [DATA_W-1:0] s;
    s           = '0;
    s[STAT_RXV] = rxv;
    s[STAT_TXR] = txr;
    s[STAT_ONE] = 1'b1;
    s[STAT_OVR] = ovr;
    return s;
  endfunction

endpackage

// File: rtl/snes_usb_fifo_ctrl_sync.sv
// Two-flop synchroniser producing a clean level plus registered rise/fall pulses.
module snes_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, rise_q, fall_q;

  // Edges are taken between the two flops so they line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      rise_q <= meta_q & ~sync_q;
      fall_q <= ~meta_q & sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/snes_usb_fifo_ctrl.sv
// SNES $21FE/$21FF port to FT245 USB FIFO sequencer with prefetch/transmit buffers.
// Optional sticky overrun status bit: define SNES_USB_OVERRUN_FLAG_EN.
module snes_usb_fifo_ctrl
  import snes_usb_pkg::*;
#(
  parameter int unsigned RD_PULSE = 3,
  parameter int unsigned WR_PULSE = 3,
  parameter int unsigned RECOVER  = 3,
  parameter int unsigned SETUP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       PARD_n,
  input  logic       PAWR_n,
  input  logic [7:0] snes_d_in,
  output logic [7:0] snes_d_out,
  output logic       snes_d_oe,
  input  logic       usb_active,
  input  logic       USB_RXFn,
  input  logic       USB_TXEn,
  output logic       USB_RDn,
  output logic       USB_WRn,
  input  logic [7:0] usb_d_in,
  output logic [7:0] usb_d_out,
  output logic       usb_d_oe
);

  logic pard_lvl, pard_rise, pard_fall;
  logic pawr_lvl, pawr_rise, pawr_fall;
  logic rxfn_s, rxf_rise, rxf_fall;
  logic txen_s, txe_rise, txe_fall;

  snes_edge_sync #(.RST_VAL(1'b1)) u_sync_pard (
    .clk(clk), .rst_n(rst_n), .async_i(PARD_n),
    .level_o(pard_lvl), .rise_o(pard_rise), .fall_o(pard_fall)
  );
  snes_edge_sync #(.RST_VAL(1'b1)) u_sync_pawr (
    .clk(clk), .rst_n(rst_n), .async_i(PAWR_n),
    .level_o(pawr_lvl), .rise_o(pawr_rise), .fall_o(pawr_fall)
  );
  snes_edge_sync #(.RST_VAL(1'b1)) u_sync_rxf (
    .clk(clk), .rst_n(rst_n), .async_i(USB_RXFn),
    .level_o(rxfn_s), .rise_o(rxf_rise), .fall_o(rxf_fall)
  );
  snes_edge_sync #(.RST_VAL(1'b1)) u_sync_txe (
    .clk(clk), .rst_n(rst_n), .async_i(USB_TXEn),
    .level_o(txen_s), .rise_o(txe_rise), .fall_o(txe_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{pard_lvl, pawr_lvl, pawr_fall, rxf_rise, rxf_fall, txe_rise, txe_fall};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              d_oe_q, d_oe_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;

  logic [DATA_W-1:0] rx_buf_q, tx_buf_q, snes_d_out_q;
  logic              rx_valid_q, tx_pending_q, rd_active_q, rd_hit_q;

  logic              rx_load_c, tx_done_c, launch_c, go_wr_c, go_rd_c;
  logic              wr_hit_c, ovr;
  logic [DATA_W-1:0] status_c;

  assign wr_hit_c = pawr_rise & (addr == ADDR_DATA);
  assign status_c = status_byte(rx_valid_q, ~tx_pending_q, ovr);

  // FSM state register and registered FIFO pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      d_oe_q  <= 1'b0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      d_oe_q  <= d_oe_d;
      d_out_q <= d_out_d;
    end
  end

  // Next-state logic; the last recovery cycle arbitrates like IDLE to hit minimum periods.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdn_d     = 1'b1;
    wrn_d     = 1'b1;
    d_oe_d    = 1'b0;
    d_out_d   = d_out_q;
    rx_load_c = 1'b0;
    tx_done_c = 1'b0;
    launch_c  = 1'b0;
    go_wr_c   = usb_active & tx_pending_q & ~txen_s;
    go_rd_c   = usb_active & ~rx_valid_q & ~rxfn_s & ~rd_active_q;

    case (state_q)
      ST_IDLE: launch_c = 1'b1;
      ST_RD_STROBE: begin
        rdn_d = 1'b0;
        if (cnt_q == '0) begin
          rdn_d     = 1'b1;
          rx_load_c = 1'b1;
          state_d   = ST_RD_RECOVER;
          cnt_d     = CNT_W'(RECOVER - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        d_oe_d = 1'b1;
        if (cnt_q == '0) begin
          wrn_d   = 1'b0;
          state_d = ST_WR_STROBE;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_STROBE: begin
        d_oe_d = 1'b1;
        wrn_d  = 1'b0;
        if (cnt_q == '0) begin
          wrn_d     = 1'b1;
          tx_done_c = 1'b1;
          state_d   = ST_WR_RECOVER;
          cnt_d     = CNT_W'(RECOVER - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_RECOVER, ST_WR_RECOVER: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          launch_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch_c) begin
      if (go_wr_c) begin
        state_d = ST_WR_SETUP;
        cnt_d   = CNT_W'(SETUP - 1);
        d_oe_d  = 1'b1;
        d_out_d = tx_buf_q;
      end else if (go_rd_c) begin
        state_d = ST_RD_STROBE;
        cnt_d   = CNT_W'(RD_PULSE - 1);
        rdn_d   = 1'b0;
      end
    end
  end

  // Buffers, flags and SNES read data; a new SNES write beats the transmit-done clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf_q     <= '0;
      tx_buf_q     <= '0;
      snes_d_out_q <= '0;
      rx_valid_q   <= 1'b0;
      tx_pending_q <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else if (!usb_active) begin
      rx_valid_q   <= 1'b0;
      tx_pending_q <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      if (rx_load_c) begin
        rx_buf_q   <= usb_d_in;
        rx_valid_q <= 1'b1;
      end else if (pard_rise && rd_hit_q) begin
        rx_valid_q <= 1'b0;
      end

      if (pard_fall && (addr == ADDR_DATA)) begin
        rd_active_q  <= 1'b1;
        rd_hit_q     <= rx_valid_q;
        snes_d_out_q <= rx_valid_q ? rx_buf_q : '0;
      end else if (pard_fall && (addr == ADDR_STAT)) begin
        snes_d_out_q <= status_c;
      end else if (pard_rise) begin
        rd_active_q <= 1'b0;
        rd_hit_q    <= 1'b0;
      end

      if (wr_hit_c) begin
        tx_buf_q     <= snes_d_in;
        tx_pending_q <= 1'b1;
      end else if (tx_done_c) begin
        tx_pending_q <= 1'b0;
      end
    end
  end

`ifdef SNES_USB_OVERRUN_FLAG_EN
  logic ovr_q, stat_rd_q, overrun_c;
  assign overrun_c = wr_hit_c & tx_pending_q & usb_active;

  // Sticky overrun, cleared when a status read ends unless a new overrun lands then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q     <= 1'b0;
      stat_rd_q <= 1'b0;
    end else begin
      if (pard_fall) begin
        stat_rd_q <= usb_active & (addr == ADDR_STAT);
      end else if (pard_rise) begin
        stat_rd_q <= 1'b0;
      end
      if (overrun_c) begin
        ovr_q <= 1'b1;
      end else if (pard_rise && stat_rd_q) begin
        ovr_q <= 1'b0;
      end
    end
  end
  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  assign snes_d_oe  = ~PARD_n & ((addr == ADDR_STAT) | (addr == ADDR_DATA)) & usb_active;
  assign snes_d_out = snes_d_out_q;
  assign USB_RDn    = rdn_q;
  assign USB_WRn    = wrn_q;
  assign usb_d_oe   = d_oe_q;
  assign usb_d_out  = d_out_q;

endmodule
